// File: rtl/param_univ_shift_sequencer_if.sv
// Interface bundling the request/response signals of param_univ_shift_sequencer.
// The slave modport is the register side, the master modport is the controller side.
interface param_univ_shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH) + 1
);
  logic             start;
  logic [2:0]       op;
  logic [AW-1:0]    amt;
  logic             msb_in;
  logic             lsb_in;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             ser_out_msb;
  logic             ser_out_lsb;

  modport slave (
    input  start, op, amt, msb_in, lsb_in, d,
    output q, busy, done, ser_out_msb, ser_out_lsb
  );

  modport master (
    output start, op, amt, msb_in, lsb_in, d,
    input  q, busy, done, ser_out_msb, ser_out_lsb
  );
endinterface

// File: rtl/param_univ_shift_sequencer.sv
// Parametrised universal shift register with a multi-bit shift sequencer.
// Ops: 000 HOLD, 001 SHR, 010 SHL, 011 LOAD, 100 ROR, 101 ROL, 110 ASR, 111 CLEAR.
// Build option USR_BARREL_EN: when defined, every shift/rotate completes on the
// accept edge through a combinational barrel shifter (busy stays 0); when
// undefined, shifts iterate one bit per clock edge.
module param_univ_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  param_univ_shift_sequencer_if.slave   bus
);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_SHR   = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_ROR   = 3'b100;
  localparam logic [2:0] OP_ROL   = 3'b101;
  localparam logic [2:0] OP_ASR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             msb_q, msb_d;
  logic             lsb_q, lsb_d;

  // One 1-bit step of a shift/rotate; non-shift ops leave the value unchanged.
  function automatic logic [WIDTH-1:0] step1(input logic [2:0] op,
                                             input logic [WIDTH-1:0] v,
                                             input logic msb,
                                             input logic lsb);
    case (op)
      OP_SHR:  step1 = {msb, v[WIDTH-1:1]};
      OP_SHL:  step1 = {v[WIDTH-2:0], lsb};
      OP_ROR:  step1 = {v[0], v[WIDTH-1:1]};
      OP_ROL:  step1 = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ASR:  step1 = {v[WIDTH-1], v[WIDTH-1:1]};
      default: step1 = v;
    endcase
  endfunction

`ifdef USR_BARREL_EN
  localparam logic [AW-1:0] AMT_W = AW'(WIDTH);

  // Full-amount shift in one shot; saturates fills for amt >= WIDTH so the
  // result equals amt repeated 1-bit steps, and rotates by amt mod WIDTH.
  function automatic logic [WIDTH-1:0] barrel(input logic [2:0] op,
                                              input logic [WIDTH-1:0] v,
                                              input logic [AW-1:0] amt,
                                              input logic msb,
                                              input logic lsb);
    logic [2*WIDTH-1:0] ext;
    logic [AW-1:0]      rot;
    logic               sat;
    sat    = (amt >= AMT_W);
    rot    = amt % AMT_W;
    ext    = '0;
    barrel = v;
    case (op)
      OP_SHR: begin
        ext    = {{WIDTH{msb}}, v} >> amt;
        barrel = sat ? {WIDTH{msb}} : ext[WIDTH-1:0];
      end
      OP_SHL: begin
        ext    = {v, {WIDTH{lsb}}} << amt;
        barrel = sat ? {WIDTH{lsb}} : ext[2*WIDTH-1:WIDTH];
      end
      OP_ROR: begin
        ext    = {v, v} >> rot;
        barrel = ext[WIDTH-1:0];
      end
      OP_ROL: begin
        ext    = {v, v} << rot;
        barrel = ext[2*WIDTH-1:WIDTH];
      end
      OP_ASR: begin
        ext    = {{WIDTH{v[WIDTH-1]}}, v} >> amt;
        barrel = sat ? {WIDTH{v[WIDTH-1]}} : ext[WIDTH-1:0];
      end
      default: barrel = v;
    endcase
  endfunction
`endif

  // Next-state and datapath decode for the IDLE/SHIFT sequencer.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    op_d    = op_q;
    msb_d   = msb_q;
    lsb_d   = lsb_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d  = bus.op;
          msb_d = bus.msb_in;
          lsb_d = bus.lsb_in;
          case (bus.op)
            OP_HOLD:  done_d = 1'b1;
            OP_LOAD: begin
              q_d    = bus.d;
              done_d = 1'b1;
            end
            OP_CLEAR: begin
              q_d    = '0;
              done_d = 1'b1;
            end
            default: begin
              if (bus.amt == '0) begin
                done_d = 1'b1;
              end else begin
`ifdef USR_BARREL_EN
                q_d    = barrel(bus.op, q_q, bus.amt, bus.msb_in, bus.lsb_in);
                done_d = 1'b1;
`else
                // The accept edge already performs the first step.
                q_d = step1(bus.op, q_q, bus.msb_in, bus.lsb_in);
                if (bus.amt == AW'(1)) begin
                  done_d = 1'b1;
                end else begin
                  state_d = S_SHIFT;
                  busy_d  = 1'b1;
                  cnt_d   = bus.amt - AW'(1);
                end
`endif
              end
            end
          endcase
        end else begin
          done_d = 1'b0;
        end
      end
      S_SHIFT: begin
        // start is ignored here; the latched op drives every step.
        q_d = step1(op_q, q_q, msb_q, lsb_q);
        if (cnt_q == AW'(1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - AW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any op in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= 3'b000;
      msb_q   <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      msb_q   <= msb_d;
      lsb_q   <= lsb_d;
    end
  end

  assign bus.q           = q_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.ser_out_msb = q_q[WIDTH-1];
  assign bus.ser_out_lsb = q_q[0];

endmodule

// File: tb/tb_param_univ_shift_sequencer.sv
// Self-checking bench for param_univ_shift_sequencer (WIDTH=8): table vectors,
// hand-written corner sequences and random ops against a bit-index model.
// Latency expectations follow the USR_BARREL_EN build setting.
module tb_param_univ_shift_sequencer;

`ifdef USR_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_SHR   = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_ROR   = 3'b100;
  localparam logic [2:0] OP_ROL   = 3'b101;
  localparam logic [2:0] OP_ASR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  param_univ_shift_sequencer_if #(.WIDTH(8), .AW(4)) bus ();

  param_univ_shift_sequencer #(.WIDTH(8), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] init;
    logic [2:0] op;
    logic [3:0] amt;
    logic       msb;
    logic       lsb;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: result bit i taken from source index arithmetic of the op.
  function automatic logic [7:0] ref_q(input logic [2:0] op, input logic [7:0] v,
                                       input int amt, input logic msb,
                                       input logic lsb, input logic [7:0] d);
    logic [7:0] r;
    int src;
    r = v;
    case (op)
      OP_HOLD:  r = v;
      OP_LOAD:  r = d;
      OP_CLEAR: r = 8'h00;
      default: begin
        for (int i = 0; i < 8; i++) begin
          case (op)
            OP_SHR: begin src = i + amt; r[i] = (src < 8) ? v[src] : msb; end
            OP_SHL: begin src = i - amt; r[i] = (src >= 0) ? v[src] : lsb; end
            OP_ROR: r[i] = v[(i + amt) % 8];
            OP_ROL: r[i] = v[(((i - amt) % 8) + 8) % 8];
            OP_ASR: begin src = i + amt; r[i] = (src < 8) ? v[src] : v[7]; end
            default: r[i] = v[i];
          endcase
        end
      end
    endcase
    return r;
  endfunction

  // Cycles from accept until done is seen high.
  function automatic int ref_lat(input logic [2:0] op, input int amt);
    if (BARREL || op == OP_HOLD || op == OP_LOAD || op == OP_CLEAR || amt == 0)
      return 1;
    return amt;
  endfunction

  // Issue one op from a negedge, wait (bounded) for done, check busy, q, latency.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [3:0] amt,
                        input logic msb, input logic lsb, input logic [7:0] d,
                        input logic [7:0] exp_q);
    int lat;
    int elat;
    elat = ref_lat(op, int'(amt));
    bus.op = op; bus.amt = amt; bus.msb_in = msb; bus.lsb_in = lsb; bus.d = d;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.op     = 3'($urandom_range(0, 7));
    bus.amt    = 4'($urandom_range(0, 15));
    bus.msb_in = 1'($urandom_range(0, 1));
    bus.lsb_in = 1'($urandom_range(0, 1));
    bus.d      = 8'($urandom_range(0, 255));
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      chk({nm, "_busy"}, bus.busy, 1);
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_busy_at_done"}, bus.busy, 0);
    chk({nm, "_q"}, bus.q, exp_q);
    @(negedge clk);
    chk({nm, "_done_pulse"}, bus.done, 0);
  endtask

  logic [7:0] mq;
  logic [7:0] ev;
  int         m;
  int         e;

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = OP_HOLD; bus.amt = 4'd0;
    bus.msb_in = 1'b0; bus.lsb_in = 1'b0; bus.d = 8'h00;

    vecs[0]  = '{8'hA5, OP_SHR,   4'd3,  1'b1, 1'b0, 8'hF4};
    vecs[1]  = '{8'h81, OP_ASR,   4'd9,  1'b0, 1'b0, 8'hFF};
    vecs[2]  = '{8'h81, OP_SHL,   4'd9,  1'b1, 1'b0, 8'h00};
    vecs[3]  = '{8'h96, OP_ROL,   4'd10, 1'b0, 1'b0, 8'h5A};
    vecs[4]  = '{8'h5A, OP_ROR,   4'd0,  1'b1, 1'b1, 8'h5A};
    vecs[5]  = '{8'h01, OP_ROR,   4'd5,  1'b0, 1'b0, 8'h08};
    vecs[6]  = '{8'h00, OP_SHL,   4'd8,  1'b0, 1'b1, 8'hFF};
    vecs[7]  = '{8'h3C, OP_HOLD,  4'd7,  1'b1, 1'b1, 8'h3C};
    vecs[8]  = '{8'h3C, OP_CLEAR, 4'd4,  1'b1, 1'b1, 8'h00};
    vecs[9]  = '{8'h80, OP_ASR,   4'd3,  1'b0, 1'b0, 8'hF0};
    vecs[10] = '{8'h0F, OP_SHR,   4'd15, 1'b0, 1'b1, 8'h00};
    vecs[11] = '{8'h12, OP_ROL,   4'd8,  1'b0, 1'b0, 8'h12};

    @(negedge clk); @(negedge clk);
    chk("reset_q", bus.q, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_q", bus.q, 0);

    // Table: load the initial value, then apply the op under test.
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("v%0d_load", i), OP_LOAD, 4'd0, 1'b0, 1'b0, vecs[i].init, vecs[i].init);
      run_op($sformatf("v%0d_op", i), vecs[i].op, vecs[i].amt, vecs[i].msb, vecs[i].lsb,
             8'h00, vecs[i].exp_q);
    end

    // Reset while an SHR amt=6 is in flight.
    run_op("rst_load", OP_LOAD, 4'd0, 1'b0, 1'b0, 8'h5A, 8'h5A);
    bus.op = OP_SHR; bus.amt = 4'd6; bus.msb_in = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_q", bus.q, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_after_done", bus.done, 0);
      chk("rst_after_q", bus.q, 0);
    end
    run_op("rst_next_load", OP_LOAD, 4'd0, 1'b0, 1'b0, 8'h3C, 8'h3C);

    // start ignored while busy; CLEAR in the done cycle is accepted.
    run_op("bb_load", OP_LOAD, 4'd0, 1'b0, 1'b0, 8'h01, 8'h01);
    bus.op = OP_ROR; bus.amt = 4'd5; bus.start = 1'b1;
    @(negedge clk);
    chk("bb_busy", bus.busy, BARREL ? 0 : 1);
    if (!BARREL) begin
      bus.op = OP_CLEAR; bus.start = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    m = 0;
    while (bus.done !== 1'b1 && m < 40) begin
      @(negedge clk);
      m++;
    end
    chk("bb_done_seen", bus.done, 1);
    chk("bb_q", bus.q, 8'h08);
    bus.op = OP_CLEAR; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("bb_clear_done", bus.done, 1);
    chk("bb_clear_q", bus.q, 0);
    @(negedge clk);
    chk("bb_clear_pulse", bus.done, 0);

    // Serial fill: SHL amt=8 lsb_in=1, ser outputs followed every cycle.
    run_op("ser_load", OP_LOAD, 4'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    bus.op = OP_SHL; bus.amt = 4'd8; bus.lsb_in = 1'b1; bus.start = 1'b1;
    m = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      m++;
      e  = BARREL ? 255 : ((1 << m) - 1);
      ev = e[7:0];
      chk("ser_q", bus.q, ev);
      chk("ser_msb", bus.ser_out_msb, ev[7]);
      chk("ser_lsb", bus.ser_out_lsb, ev[0]);
    end while (bus.done !== 1'b1 && m < 20);
    chk("ser_latency", m, BARREL ? 1 : 8);
    @(negedge clk);

    // Random ops against the reference model.
    mq = 8'($urandom_range(0, 255));
    run_op("rnd_init", OP_LOAD, 4'd0, 1'b0, 1'b0, mq, mq);
    for (int n = 0; n < 150; n++) begin
      logic [2:0] rop;
      logic [3:0] ramt;
      logic       rmsb;
      logic       rlsb;
      logic [7:0] rd;
      rop  = 3'($urandom_range(0, 7));
      ramt = 4'($urandom_range(0, 15));
      rmsb = 1'($urandom_range(0, 1));
      rlsb = 1'($urandom_range(0, 1));
      rd   = 8'($urandom_range(0, 255));
      mq   = ref_q(rop, mq, int'(ramt), rmsb, rlsb, rd);
      run_op($sformatf("rnd%0d_op%0d_amt%0d", n, rop, ramt), rop, ramt, rmsb, rlsb, rd, mq);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
